// File: rtl/obco_deadtime_if.sv
// rtl/obco_deadtime_if.sv - control, data and complementary output bundle for obco_deadtime
interface obco_deadtime_if #(
    parameter int CHANNELS = 4,
    parameter int DT_WIDTH = 8
);
    logic                EN;
    logic [DT_WIDTH-1:0] DT;
    logic [CHANNELS-1:0] I;
    logic [CHANNELS-1:0] OT;
    logic [CHANNELS-1:0] OC;
    logic                BUSY;

    modport master (
        output EN,
        output DT,
        output I,
        input  OT,
        input  OC,
        input  BUSY
    );

    modport slave (
        input  EN,
        input  DT,
        input  I,
        output OT,
        output OC,
        output BUSY
    );
endinterface

// File: rtl/obco_deadtime.sv
// rtl/obco_deadtime.sv - multi-channel complementary driver with break-before-make dead time
module obco_deadtime #(
    parameter int CHANNELS = 4,
    parameter int DT_WIDTH = 8
) (
    input  logic              CLK,
    input  logic              RSTN,
    obco_deadtime_if.slave    bus
);

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2,
        ST_DEAD = 2'd3
    } state_t;

    logic [CHANNELS-1:0]               i_q;
    logic [CHANNELS-1:0]               i_d;
    state_t [CHANNELS-1:0]             state_q;
    state_t [CHANNELS-1:0]             state_d;
    logic [CHANNELS-1:0][DT_WIDTH-1:0] cnt_q;
    logic [CHANNELS-1:0][DT_WIDTH-1:0] cnt_d;
    logic [CHANNELS-1:0]               ot_q;
    logic [CHANNELS-1:0]               ot_d;
    logic [CHANNELS-1:0]               oc_q;
    logic [CHANNELS-1:0]               oc_d;
    logic                              busy_q;
    logic                              busy_d;
    logic                              dt_zero;
    logic [DT_WIDTH-1:0]               dt_load;

    assign i_d     = bus.I;
    assign dt_zero = (bus.DT == '0);
    assign dt_load = bus.DT - DT_WIDTH'(1);

    // Outputs are decoded from the next state so OT/OC/BUSY change on the same edge as the state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ot_d    = '0;
        oc_d    = '0;
        busy_d  = 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
            case (state_q[k])
                ST_OFF: begin
                    if (bus.EN) begin
                        state_d[k] = i_q[k] ? ST_HIGH : ST_LOW;
                    end
                end
                ST_HIGH: begin
                    if (!bus.EN) begin
                        state_d[k] = ST_OFF;
                        cnt_d[k]   = '0;
                    end else if (!i_q[k]) begin
                        if (dt_zero) begin
                            state_d[k] = ST_LOW;
                        end else begin
                            state_d[k] = ST_DEAD;
                            cnt_d[k]   = dt_load;
                        end
                    end
                end
                ST_LOW: begin
                    if (!bus.EN) begin
                        state_d[k] = ST_OFF;
                        cnt_d[k]   = '0;
                    end else if (i_q[k]) begin
                        if (dt_zero) begin
                            state_d[k] = ST_HIGH;
                        end else begin
                            state_d[k] = ST_DEAD;
                            cnt_d[k]   = dt_load;
                        end
                    end
                end
                ST_DEAD: begin
                    // Exit level follows the live input, so a glitch that reverts still pays full dead time.
                    if (!bus.EN) begin
                        state_d[k] = ST_OFF;
                        cnt_d[k]   = '0;
                    end else if (cnt_q[k] == '0) begin
                        state_d[k] = i_q[k] ? ST_HIGH : ST_LOW;
                    end else begin
                        cnt_d[k] = cnt_q[k] - DT_WIDTH'(1);
                    end
                end
                default: begin
                    state_d[k] = ST_OFF;
                    cnt_d[k]   = '0;
                end
            endcase
            ot_d[k] = (state_d[k] == ST_HIGH);
            oc_d[k] = (state_d[k] == ST_LOW);
            busy_d  = busy_d | (state_d[k] == ST_DEAD);
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            i_q    <= '0;
            ot_q   <= '0;
            oc_q   <= '0;
            busy_q <= 1'b0;
            for (int k = 0; k < CHANNELS; k++) begin
                state_q[k] <= ST_OFF;
                cnt_q[k]   <= '0;
            end
        end else begin
            i_q     <= i_d;
            ot_q    <= ot_d;
            oc_q    <= oc_d;
            busy_q  <= busy_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.OT   = ot_q;
    assign bus.OC   = oc_q;
    assign bus.BUSY = busy_q;

endmodule

// File: tb/tb_obco_deadtime.sv
// tb/tb_obco_deadtime.sv - self-checking bench for obco_deadtime
module tb_obco_deadtime;

    typedef struct {
        logic       en;
        logic [7:0] dt;
        logic [3:0] i;
        logic [3:0] ot;
        logic [3:0] oc;
        logic       busy;
    } vec_t;

    typedef struct {
        logic [3:0] ot;
        logic [3:0] oc;
        logic       busy;
        int         row;
    } exp_t;

    logic clk;
    logic rstn;
    logic inv_on;
    int   checks;
    int   errors;
    vec_t vecs[29];
    exp_t sb[$];

    obco_deadtime_if #(.CHANNELS(4), .DT_WIDTH(8)) bus ();

    obco_deadtime #(.CHANNELS(4), .DT_WIDTH(8)) dut (
        .CLK  (clk),
        .RSTN (rstn),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (inv_on) begin
            checks++;
            if ((bus.OT & bus.OC) != 4'b0000) begin
                errors++;
                $display("FAIL invariant actual=%b required=0000 at %0t", bus.OT & bus.OC, $time);
            end
        end
    end

    function automatic vec_t mk(input logic en, input logic [7:0] dt, input logic [3:0] i,
                                input logic [3:0] ot, input logic [3:0] oc, input logic busy);
        vec_t v;
        v.en = en; v.dt = dt; v.i = i; v.ot = ot; v.oc = oc; v.busy = busy;
        return v;
    endfunction

    initial begin
        int dead[4];
        int busy_cnt;
        bit done;
        exp_t e;

        checks = 0;
        errors = 0;
        inv_on = 1'b0;

        // Release with DT=0, then DT=0 toggling of channel 1, EN drop and re-enable
        vecs[0]  = mk(1, 0, 4'b0101, 4'b0000, 4'b1111, 0);
        vecs[1]  = mk(1, 0, 4'b0101, 4'b0101, 4'b1010, 0);
        vecs[2]  = mk(1, 0, 4'b0111, 4'b0101, 4'b1010, 0);
        vecs[3]  = mk(1, 0, 4'b0101, 4'b0111, 4'b1000, 0);
        vecs[4]  = mk(1, 0, 4'b0111, 4'b0101, 4'b1010, 0);
        vecs[5]  = mk(1, 0, 4'b0101, 4'b0111, 4'b1000, 0);
        vecs[6]  = mk(1, 0, 4'b0111, 4'b0101, 4'b1010, 0);
        vecs[7]  = mk(1, 0, 4'b0101, 4'b0111, 4'b1000, 0);
        vecs[8]  = mk(0, 0, 4'b0101, 4'b0000, 4'b0000, 0);
        vecs[9]  = mk(1, 0, 4'b0101, 4'b0101, 4'b1010, 0);
        // DT=3 on channel 0 falling
        vecs[10] = mk(1, 3, 4'b0100, 4'b0101, 4'b1010, 0);
        vecs[11] = mk(1, 3, 4'b0100, 4'b0100, 4'b1010, 1);
        vecs[12] = mk(1, 3, 4'b0100, 4'b0100, 4'b1010, 1);
        vecs[13] = mk(1, 3, 4'b0100, 4'b0100, 4'b1010, 1);
        vecs[14] = mk(1, 3, 4'b0100, 4'b0100, 4'b1011, 0);
        // DT=5 glitch on channel 2
        vecs[15] = mk(1, 5, 4'b0000, 4'b0100, 4'b1011, 0);
        vecs[16] = mk(1, 5, 4'b0000, 4'b0000, 4'b1011, 1);
        vecs[17] = mk(1, 5, 4'b0100, 4'b0000, 4'b1011, 1);
        vecs[18] = mk(1, 5, 4'b0100, 4'b0000, 4'b1011, 1);
        vecs[19] = mk(1, 5, 4'b0100, 4'b0000, 4'b1011, 1);
        vecs[20] = mk(1, 5, 4'b0100, 4'b0000, 4'b1011, 1);
        vecs[21] = mk(1, 5, 4'b0100, 4'b0100, 4'b1011, 0);
        // DT=10 on channel 3 rising, EN dropped after 4 dead cycles
        vecs[22] = mk(1, 10, 4'b1100, 4'b0100, 4'b1011, 0);
        vecs[23] = mk(1, 10, 4'b1100, 4'b0100, 4'b0011, 1);
        vecs[24] = mk(1, 10, 4'b1100, 4'b0100, 4'b0011, 1);
        vecs[25] = mk(1, 10, 4'b1100, 4'b0100, 4'b0011, 1);
        vecs[26] = mk(1, 10, 4'b1100, 4'b0100, 4'b0011, 1);
        vecs[27] = mk(0, 10, 4'b1100, 4'b0000, 4'b0000, 0);
        vecs[28] = mk(1, 10, 4'b1100, 4'b1100, 4'b0011, 0);

        rstn    = 1'b0;
        bus.EN  = 1'b1;
        bus.DT  = 8'd0;
        bus.I   = 4'b0101;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ot", 32'(bus.OT), 32'h0);
        chk("reset_oc", 32'(bus.OC), 32'h0);
        chk("reset_busy", 32'(bus.BUSY), 32'h0);
        @(negedge clk);
        rstn   = 1'b1;
        inv_on = 1'b1;

        for (int r = 0; r < 29; r++) begin
            bus.EN = vecs[r].en;
            bus.DT = vecs[r].dt;
            bus.I  = vecs[r].i;
            e.ot = vecs[r].ot; e.oc = vecs[r].oc; e.busy = vecs[r].busy; e.row = r;
            sb.push_back(e);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            chk($sformatf("row%0d_ot", e.row), 32'(bus.OT), 32'(e.ot));
            chk($sformatf("row%0d_oc", e.row), 32'(bus.OC), 32'(e.oc));
            chk($sformatf("row%0d_busy", e.row), 32'(bus.BUSY), 32'(e.busy));
        end

        // All channels toggle together at maximum dead time; DT changes mid-count
        bus.DT = 8'd255;
        bus.I  = 4'b0011;
        @(posedge clk);
        #1;
        chk("max_edge0_ot", 32'(bus.OT), 32'hC);
        for (int k = 0; k < 4; k++) dead[k] = 0;
        busy_cnt = 0;
        done     = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            if (c == 10) bus.DT = 8'd2;
            @(posedge clk);
            #1;
            for (int k = 0; k < 4; k++) begin
                if (!bus.OT[k] && !bus.OC[k]) dead[k]++;
            end
            if (bus.BUSY) busy_cnt++;
            if (bus.OT == 4'b0011 && bus.OC == 4'b1100) done = 1'b1;
        end
        chk("max_timeout", 32'(done), 32'h1);
        for (int k = 0; k < 4; k++) chk($sformatf("max_dead_ch%0d", k), 32'(dead[k]), 32'd255);
        chk("max_busy_cycles", 32'(busy_cnt), 32'd255);
        chk("max_final_oc", 32'(bus.OC), 32'hC);

        // Asynchronous reset mid-run while outputs are high
        @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        chk("async_rst_ot", 32'(bus.OT), 32'h0);
        chk("async_rst_oc", 32'(bus.OC), 32'h0);
        chk("async_rst_busy", 32'(bus.BUSY), 32'h0);
        inv_on = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/obco_deadtime.md
Name: obco_deadtime

Overview:
- Multi-channel complementary output driver.
- Each channel drives a true output OT and a complement output OC from one input I, like a complementary output buffer.
- Between every OT/OC handover it inserts a programmable break-before-make dead time, so the two outputs are never high together.
- Sits before complementary/differential pad pairs, e.g. gate drivers and LVDS-emulation pairs.

Parameters:
- CHANNELS, 4: number of independent complementary channels (≥1).
- DT_WIDTH, 8: width of the dead-time count DT (≥1).

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RSTN  input  1  asynchronous active-low reset.
- EN  input  1  global enable; 0 forces all channels to OFF.
- DT  input  DT_WIDTH  dead-time length in CLK cycles; sampled per channel on entry to DEAD.
- I  input  CHANNELS  per-channel data input.
- OT  output  CHANNELS  true outputs; registered.
- OC  output  CHANNELS  complement outputs; registered.
- BUSY  output  1  OR over channels of (state == DEAD); registered.

Behaviour:
- Clocking and reset:
  - One clock; reset is asynchronous and active-low.
  - RSTN low: every i_q=0, state=OFF, cnt=0, OT=0, OC=0, BUSY=0, immediately and without a clock.
  - Release is synchronous to CLK in effect: the first state change can occur on the first rising edge after RSTN goes high.
- Input stage: each I bit is registered into i_q every edge, regardless of EN. No synchroniser; I is in the CLK domain.
- Per-channel FSM, 2-bit state plus DT_WIDTH-bit counter:
  - OFF: OT=0, OC=0.
    - If EN=1: go to HIGH if i_q=1, else LOW. No dead time, since both outputs are already low.
  - HIGH: OT=1, OC=0.
    - EN=0 → OFF.
    - Else if i_q=0: DT≠0 → DEAD with cnt=DT-1 and tgt=0; DT=0 → LOW directly.
  - LOW: OT=0, OC=1.
    - EN=0 → OFF.
    - Else if i_q=1: DT≠0 → DEAD with cnt=DT-1 and tgt=1; DT=0 → HIGH directly.
  - DEAD: OT=0, OC=0.
    - EN=0 → OFF.
    - Else if cnt==0: go to HIGH if i_q=1, else LOW. The level is re-evaluated from the current i_q, not tgt.
    - Else cnt decrements.
- Timing:
  - I toggles before edge 0 (captured into i_q at edge 0). The old output deasserts at edge 1. The new output asserts at edge 1+DT.
  - Both outputs are low for exactly DT cycles.
  - DT=0 gives a direct swap at edge 1.
- Input activity during DEAD:
  - Changes on i_q neither restart nor shorten the count.
  - If I returns to the old level, DEAD still completes, then re-enters the old state. This gives at least DT cycles of off time on every glitch.
- DT handling:
  - A DT change while a channel is in DEAD does not affect the running count.
  - Maximum dead time is 2^DT_WIDTH-1 cycles; no wrap.
- Invariant: OT[k]&OC[k] is 0 on every cycle, including reset, EN edges and DT=0 swaps. All outputs come from flops, so there are no combinational paths from inputs to outputs.
- EN and reset mid-operation:
  - EN falling mid-DEAD: OFF on the next edge; the count is discarded.
  - EN rising: one edge to leave OFF.
  - RSTN asserted at any point aborts everything asynchronously.
- BUSY is registered with the state, i.e. it reflects the DEAD state of the current cycle.
- Channels are fully independent; simultaneous toggles on several channels each run their own counters.

Test Plan:
1. Reset/enable:
   - Stimulus: RSTN=0 mid-run with OT=1.
   - Required: OT=OC=0 and BUSY=0 before the next CLK edge.
   - Stimulus: release with EN=1, I=4'b0101.
   - Required: edge 1 after release gives OT=0101, OC=1010.
2. Dead time:
   - Stimulus: DT=3, channel 0 held HIGH, I[0] 1→0 before edge 0.
   - Required: OT[0]=0 from edge 1; OC[0]=1 at edge 4; both low for exactly 3 cycles; BUSY=1 during those cycles only.
3. DT=0 swap:
   - Stimulus: toggle I[1] each cycle.
   - Required: OT[1]/OC[1] swap every edge, one cycle after i_q; OT&OC never 1; BUSY stays 0.
4. Glitch during DEAD:
   - Stimulus: DT=5, I[2] 1→0, then back to 1 two cycles later.
   - Required: outputs low for 5 cycles, then OT[2]=1; OC[2] never asserts.
5. EN drop mid-DEAD:
   - Stimulus: DT=10, start a transition, deassert EN after 4 cycles.
   - Required: channel OFF at the next edge and BUSY=0.
   - Stimulus: re-assert EN.
   - Required: the output matching i_q asserts one edge later, with no dead time.
6. Concurrency and extremes:
   - Stimulus: all channels toggled together with DT=255 (max, DT_WIDTH=8); change DT to 2 mid-count.
   - Required: every channel stays dead for exactly 255 cycles; the invariant OT&OC=0 holds on every cycle.
